// File: rtl/store_rmw_ctrl_if.sv
// Store controller bus: MEM-stage request/response plus the data RAM port.
// The shared store op encodings live in the package at the top of this file.
package store_rmw_pkg;
    localparam logic [1:0] STORE_SB = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SW = 2'b10;
endpackage

interface store_rmw_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              cache_inv;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        input  cache_inv, ram_rdata,
        output req_ready, ram_en, ram_we, ram_addr,
        output ram_wdata, busy, done, err
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        output cache_inv, ram_rdata,
        input  req_ready, ram_en, ram_we, ram_addr,
        input  ram_wdata, busy, done, err
    );
endinterface

// File: rtl/store_rmw_ctrl.sv
// Store sequencer for a byte-enable-less RAM: SB/SH via read-modify-write.
// Optional one-word bypass cache enabled by defining STORE_RMW_BYPASS_EN.
module store_rmw_ctrl
    import store_rmw_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    store_rmw_ctrl_if.slave         bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_FAIL
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;

    logic              accept;
    logic [1:0]        in_lane;
    logic [ADDR_W-1:0] in_addr;
    logic              in_sw_ok;
    logic              in_rmw_ok;
    logic              hit;

    assign accept    = bus.req_valid && (state_q == S_IDLE);
    assign in_lane   = bus.req_addr[1:0];
    assign in_addr   = bus.req_addr[ADDR_W+1:2];
    assign in_sw_ok  = (bus.req_op == STORE_SW) && (in_lane == 2'd0);
    assign in_rmw_ok = (bus.req_op == STORE_SB) ||
                       ((bus.req_op == STORE_SH) && !in_lane[0]);

    // Replace only the addressed byte/halfword of the old word.
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_w,
        input logic [31:0] src,
        input logic [1:0]  op,
        input logic [1:0]  lane
    );
        logic [31:0] w;
        w = old_w;
        if (op == STORE_SB) begin
            w[{lane, 3'b000} +: 8] = src[7:0];
        end else if (op == STORE_SH) begin
            w[{lane[1], 4'b0000} +: 16] = src[15:0];
        end
        return w;
    endfunction

`ifdef STORE_RMW_BYPASS_EN
    logic              cvld_q;
    logic [ADDR_W-1:0] caddr_q;
    logic [31:0]       cword_q;

    assign hit = cvld_q && (caddr_q == in_addr) && !bus.cache_inv;

    // Bypass entry mirrors the last word written; invalidate wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cvld_q  <= 1'b0;
            caddr_q <= '0;
            cword_q <= '0;
        end else if (bus.cache_inv) begin
            cvld_q  <= 1'b0;
        end else if (state_q == S_WRITE) begin
            cvld_q  <= 1'b1;
            caddr_q <= addr_q;
            cword_q <= data_q;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = bus.cache_inv;
    assign hit = 1'b0;
`endif

    logic unused_hi;
    assign unused_hi = ^bus.req_addr[31:ADDR_W+2];

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = bus.req_op;
                    lane_d = in_lane;
                    addr_d = in_addr;
                    data_d = bus.req_wdata;
                    if (in_sw_ok) begin
                        state_d = S_WRITE;
                    end else if (in_rmw_ok) begin
                        state_d = S_READ;
`ifdef STORE_RMW_BYPASS_EN
                        if (hit) begin
                            state_d = S_WRITE;
                            data_d  = merge_word(cword_q,
                                                 bus.req_wdata,
                                                 bus.req_op,
                                                 in_lane);
                        end
`endif
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_READ: begin
                state_d = S_MERGE;
            end
            S_MERGE: begin
                data_d  = merge_word(bus.ram_rdata, data_q,
                                     op_q, lane_q);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            lane_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    logic unused_hit;
    assign unused_hit = hit;

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ram_en    = (state_q == S_READ) ||
                           (state_q == S_WRITE);
    assign bus.ram_we    = (state_q == S_WRITE);
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = data_q;
    assign bus.done      = (state_q == S_WRITE) ||
                           (state_q == S_FAIL);
    assign bus.err       = (state_q == S_FAIL);

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl with a behavioural single-port RAM.
// Define STORE_RMW_BYPASS_EN to also exercise the bypass cache.
module tb_store_rmw_ctrl;
    import store_rmw_pkg::*;

    localparam int AW = 14;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   we_total;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;
    logic [31:0]   mem [0:(1<<AW)-1];

    store_rmw_ctrl_if #(.ADDR_W(AW)) bus ();

    store_rmw_ctrl #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial we_total = 0;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
        if (bus.ram_we) we_total <= we_total + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk); #1;
        bd_we   = 1'b0;
    endtask

    int   dc, fr, nen, nwr;
    logic e;

    task automatic run(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input bit inv);
        dc  = -1;
        fr  = -1;
        nen = 0;
        nwr = 0;
        e   = 1'bx;
        chk("ready_before", 32'(bus.req_ready), 32'd1);
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.cache_inv = inv;
        bus.req_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            bus.cache_inv = 1'b0;
            if (bus.ram_en) nen++;
            if (bus.ram_en && !bus.ram_we && fr < 0) fr = c;
            if (bus.ram_we) nwr++;
            if (bus.done) begin
                dc = c;
                e  = bus.err;
                break;
            end
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    int we_snap;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        bus.req_valid = 1'b0;
        bus.req_op    = STORE_SW;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.cache_inv = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        chk("rst_err",   32'(bus.err),       32'd0);
        chk("rst_en",    32'(bus.ram_en),    32'd0);
        chk("rst_we",    32'(bus.ram_we),    32'd0);
        chk("rst_addr",  32'(bus.ram_addr),  32'd0);
        chk("rst_wdata", bus.ram_wdata,      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        poke(14'd5, 32'h11223344);
        run(STORE_SB, 32'h16, 32'h000000AB, 1'b1);
        chk("sb_done_cyc", 32'(dc), 32'd3);
        chk("sb_read_cyc", 32'(fr), 32'd1);
        chk("sb_writes",   32'(nwr), 32'd1);
        chk("sb_err",      32'(e), 32'd0);
        chk("sb_ram5",     mem[5], 32'h11AB3344);

        poke(14'd2, 32'hDEADBEEF);
        run(STORE_SH, 32'h0A, 32'h00001234, 1'b1);
        chk("sh2_done_cyc", 32'(dc), 32'd3);
        chk("sh2_ram2",     mem[2], 32'h1234BEEF);
        run(STORE_SH, 32'h08, 32'h00005678, 1'b1);
        chk("sh0_ram2",     mem[2], 32'h12345678);
        chk("sh0_err",      32'(e), 32'd0);

        run(STORE_SB, 32'h17, 32'hFFFFFF99, 1'b1);
        chk("sb3_ram5", mem[5], 32'h99AB3344);
        run(STORE_SB, 32'h14, 32'h00000001, 1'b1);
        chk("sb0_ram5", mem[5], 32'h99AB3301);
        run(STORE_SB, 32'h15, 32'h000000C3, 1'b1);
        chk("sb1_ram5", mem[5], 32'h99ABC301);

        run(STORE_SW, 32'h20, 32'hCAFEF00D, 1'b1);
        chk("sw_done_cyc", 32'(dc), 32'd1);
        chk("sw_en_cnt",   32'(nen), 32'd1);
        chk("sw_no_read",  32'(fr), 32'hFFFFFFFF);
        chk("sw_err",      32'(e), 32'd0);
        chk("sw_ram8",     mem[8], 32'hCAFEF00D);

        we_snap = we_total;
        run(STORE_SH, 32'h0B, 32'h0000FFFF, 1'b1);
        chk("shmis_done_cyc", 32'(dc), 32'd1);
        chk("shmis_err",      32'(e), 32'd1);
        chk("shmis_en",       32'(nen), 32'd0);
        chk("shmis_ram2",     mem[2], 32'h12345678);
        run(STORE_SW, 32'h21, 32'h00000000, 1'b1);
        chk("swmis_done_cyc", 32'(dc), 32'd1);
        chk("swmis_err",      32'(e), 32'd1);
        chk("swmis_en",       32'(nen), 32'd0);
        chk("swmis_ram8",     mem[8], 32'hCAFEF00D);
        run(2'b11, 32'h20, 32'h00000000, 1'b1);
        chk("badop_err",  32'(e), 32'd1);
        chk("badop_en",   32'(nen), 32'd0);
        chk("badop_ram8", mem[8], 32'hCAFEF00D);
        chk("err_no_we",  32'(we_total - we_snap), 32'd0);

        poke(14'd9, 32'h01020304);
        we_snap = we_total;
        bus.req_op    = STORE_SB;
        bus.req_addr  = 32'h24;
        bus.req_wdata = 32'h000000EE;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_read", 32'(bus.ram_en), 32'd1);
        @(posedge clk); #1;
        chk("rst_mid_merge_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we",    32'(bus.ram_we),    32'd0);
        chk("rst_mid_en",    32'(bus.ram_en),    32'd0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_done",  32'(bus.done),      32'd0);
        chk("rst_mid_busy",  32'(bus.busy),      32'd0);
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ram9", mem[9], 32'h01020304);
        chk("rst_mid_nowe", 32'(we_total - we_snap), 32'd0);
        chk("rst_mid_rdy2", 32'(bus.req_ready), 32'd1);

`ifdef STORE_RMW_BYPASS_EN
        run(STORE_SW, 32'h40, 32'h00000000, 1'b1);
        chk("byp_sw_done", 32'(dc), 32'd1);
        run(STORE_SB, 32'h41, 32'h0000007F, 1'b0);
        chk("byp_hit_done", 32'(dc), 32'd1);
        chk("byp_hit_read", 32'(fr), 32'hFFFFFFFF);
        chk("byp_hit_en",   32'(nen), 32'd1);
        chk("byp_hit_ram",  mem[16], 32'h00007F00);
        bus.cache_inv = 1'b1;
        @(posedge clk); #1;
        bus.cache_inv = 1'b0;
        run(STORE_SB, 32'h42, 32'h00000055, 1'b0);
        chk("byp_inv_done", 32'(dc), 32'd3);
        chk("byp_inv_read", 32'(fr), 32'd1);
        chk("byp_inv_ram",  mem[16], 32'h00557F00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
